// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: the pipeline-facing bundle of the CP0 register file.
//   master : the M-stage pipeline side. It drives the mfc0/mtc0 fields, the
//            PC and BD of the instruction in M, its final ExcCode, the
//            hardware interrupt lines and the eret clear. It receives the
//            exception request, the handler address, EPC and the mfc0 data.
//   slave  : the CP0 register file side, with the opposite directions.
// Handshake: the bus carries no valid/ready pair. Every input is qualified
// by its own strobe (WE, EXLClr, ExcCode != 0). IntReq is a combinational
// response in the same cycle. The register side effects of a request land
// on the next rising edge of clk.
interface cp0_regfile_if;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        BD;
   logic [6:2]  ExcCode;
   logic [7:2]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] HandlerPC;
   logic [31:0] EPC;
   logic [31:0] DOut;

   modport master (
      output A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
      input  IntReq, HandlerPC, EPC, DOut
   );

   modport slave (
      input  A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
      output IntReq, HandlerPC, EPC, DOut
   );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file with an exception/interrupt
// arbiter. It sits after the M-stage exception checker.
// Ports:
//   clk    : system clock. All state updates happen on its rising edge.
//   reset  : synchronous, active-high reset. It clears SR, Cause and EPC.
//   bus    : cp0_regfile_if.slave, which carries these signals:
//            A1/DOut     - mfc0 read port, combinational.
//            A2/DIn/WE   - mtc0 write port.
//            PC/BD       - PC and branch-delay flag of the instruction in M.
//            ExcCode     - final exception code for M. A value of 0 means none.
//            HWInt       - external interrupt lines.
//            EXLClr      - eret in M.
//            IntReq      - take an exception this cycle. It flushes the
//                          pipeline and redirects fetch to HandlerPC.
//            HandlerPC   - constant exception entry address.
//            EPC         - current EPC value, used as the eret target.
// Registers: SR(12), Cause(13), EPC(14) and PrID(15). Any other number
// reads as 0.
module cp0_regfile #(
   parameter logic [31:0] PRID         = 32'h4C57_0001,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
   input logic          clk,
   input logic          reset,
   cp0_regfile_if.slave bus
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:2] epc_q;

   logic        int_req;
   logic        exc_req;
   logic        take;
   logic [4:0]  rec_code;
   logic [31:2] epc_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // EXL masks every new request, so nested exceptions cannot occur.
   assign int_req  = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
   assign exc_req  = (bus.ExcCode != 5'd0) & ~sr_exl;
   assign take     = int_req | exc_req;
   // An interrupt takes priority over a synchronous exception and records code 0.
   assign rec_code = int_req ? 5'd0 : bus.ExcCode;
   // EPC points at the branch when M is in a delay slot. The subtraction wraps
   // modulo 2^32. Only bits [31:2] are stored, so subtracting 4 is subtracting
   // 1 from PC[31:2].
   assign epc_next = bus.BD ? (bus.PC[31:2] - 30'd1) : bus.PC[31:2];

   assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

   assign bus.IntReq    = take;
   assign bus.HandlerPC = HANDLER_ADDR;
   assign bus.EPC       = {epc_q, 2'b00};

   // mfc0 returns the value held before the edge. A write made in the same
   // cycle is not bypassed to the read port.
   always_comb begin
      bus.DOut = 32'd0;
      case (bus.A1)
         5'd12:   bus.DOut = sr_word;
         5'd13:   bus.DOut = cause_word;
         5'd14:   bus.DOut = {epc_q, 2'b00};
         5'd15:   bus.DOut = PRID;
         default: bus.DOut = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'd0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc_q     <= 30'd0;
      end else begin
         // IP mirrors the interrupt lines. mtc0 cannot write it.
         cause_ip <= bus.HWInt;
         if (take) begin
            // Exception entry wins over a write or eret in the same cycle.
            sr_exl    <= 1'b1;
            cause_bd  <= bus.BD;
            cause_exc <= rec_code;
            epc_q     <= epc_next;
         end else begin
            if (bus.WE) begin
               case (bus.A2)
                  5'd12: begin
                     sr_im  <= bus.DIn[15:10];
                     sr_exl <= bus.DIn[1];
                     sr_ie  <= bus.DIn[0];
                  end
                  5'd14:   epc_q <= bus.DIn[31:2];
                  default: ;
               endcase
            end
            if (bus.EXLClr) sr_exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

   localparam logic [31:0] PRID         = 32'h4C57_0001;
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   cp0_regfile_if bus ();

   cp0_regfile #(
      .PRID        (PRID),
      .HANDLER_ADDR(HANDLER_ADDR)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks.
   task automatic idle();
      bus.A1      = 5'd0;
      bus.A2      = 5'd0;
      bus.DIn     = 32'd0;
      bus.WE      = 1'b0;
      bus.PC      = 32'd0;
      bus.BD      = 1'b0;
      bus.ExcCode = 5'd0;
      bus.EXLClr  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.WE  = 1'b1;
      bus.A2  = a;
      bus.DIn = d;
      step();
      bus.WE  = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      bus.HWInt = 6'd0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      bus.HWInt = 6'h3F;
      #1;
      bus.A1 = 5'd15; #1;
      total_cnt++;
      if (bus.DOut !== PRID) $display("FAIL reset_prid got=%h exp=%h", bus.DOut, PRID);
      else pass_cnt++;
      bus.A1 = 5'd12; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL reset_sr got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL reset_cause got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      bus.A1 = 5'd14; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL reset_epc_read got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      bus.A1 = 5'd7; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL reset_unmapped got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      total_cnt++;
      if (bus.IntReq !== 1'b0) $display("FAIL reset_intreq_ie0 got=%b exp=0", bus.IntReq);
      else pass_cnt++;
      total_cnt++;
      if (bus.EPC !== 32'd0) $display("FAIL reset_epc_out got=%h exp=%h", bus.EPC, 32'd0);
      else pass_cnt++;
      total_cnt++;
      if (bus.HandlerPC !== HANDLER_ADDR) $display("FAIL handler_pc got=%h exp=%h", bus.HandlerPC, HANDLER_ADDR);
      else pass_cnt++;
      bus.HWInt = 6'd0;
      step();
   endtask

   task automatic test_int_entry();
      mtc0(5'd12, 32'h0000_0401);
      bus.A1 = 5'd12; #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0401) $display("FAIL int_sr_write got=%h exp=%h", bus.DOut, 32'h0000_0401);
      else pass_cnt++;
      bus.HWInt = 6'b000001;
      bus.PC    = 32'h0000_1000;
      bus.BD    = 1'b0;
      #1;
      total_cnt++;
      if (bus.IntReq !== 1'b1) $display("FAIL int_req got=%b exp=1", bus.IntReq);
      else pass_cnt++;
      step();
      bus.PC = 32'h0000_1004;
      bus.A1 = 5'd12; #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0403) $display("FAIL int_sr_exl got=%h exp=%h", bus.DOut, 32'h0000_0403);
      else pass_cnt++;
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0400) $display("FAIL int_cause got=%h exp=%h", bus.DOut, 32'h0000_0400);
      else pass_cnt++;
      total_cnt++;
      if (bus.EPC !== 32'h0000_1000) $display("FAIL int_epc got=%h exp=%h", bus.EPC, 32'h0000_1000);
      else pass_cnt++;
      total_cnt++;
      if (bus.IntReq !== 1'b0) $display("FAIL int_masked_exl got=%b exp=0", bus.IntReq);
      else pass_cnt++;
      bus.HWInt = 6'd0;
      idle();
      step();
   endtask

   task automatic test_exc_entry();
      mtc0(5'd12, 32'h0000_0401);
      bus.ExcCode = 5'd5;
      bus.PC      = 32'h0000_3010;
      bus.BD      = 1'b1;
      #1;
      total_cnt++;
      if (bus.IntReq !== 1'b1) $display("FAIL exc_req got=%b exp=1", bus.IntReq);
      else pass_cnt++;
      step();
      idle();
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.EPC !== 32'h0000_300C) $display("FAIL exc_epc_bd got=%h exp=%h", bus.EPC, 32'h0000_300C);
      else pass_cnt++;
      total_cnt++;
      if (bus.DOut !== 32'h8000_0014) $display("FAIL exc_cause got=%h exp=%h", bus.DOut, 32'h8000_0014);
      else pass_cnt++;
      // While EXL is set, a further exception is ignored and changes no state.
      bus.ExcCode = 5'd4;
      bus.PC      = 32'h0000_5000;
      bus.BD      = 1'b0;
      #1;
      total_cnt++;
      if (bus.IntReq !== 1'b0) $display("FAIL exc_masked got=%b exp=0", bus.IntReq);
      else pass_cnt++;
      step();
      bus.ExcCode = 5'd0;
      #1;
      total_cnt++;
      if (bus.DOut !== 32'h8000_0014) $display("FAIL exc_masked_cause got=%h exp=%h", bus.DOut, 32'h8000_0014);
      else pass_cnt++;
      total_cnt++;
      if (bus.EPC !== 32'h0000_300C) $display("FAIL exc_masked_epc got=%h exp=%h", bus.EPC, 32'h0000_300C);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_priority();
      mtc0(5'd12, 32'h0000_0401);
      bus.HWInt   = 6'b000001;
      bus.ExcCode = 5'd12;
      bus.WE      = 1'b1;
      bus.A2      = 5'd14;
      bus.DIn     = 32'hDEAD_0000;
      bus.PC      = 32'h0000_2000;
      bus.BD      = 1'b0;
      #1;
      total_cnt++;
      if (bus.IntReq !== 1'b1) $display("FAIL prio_req got=%b exp=1", bus.IntReq);
      else pass_cnt++;
      step();
      idle();
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0400) $display("FAIL prio_cause got=%h exp=%h", bus.DOut, 32'h0000_0400);
      else pass_cnt++;
      total_cnt++;
      if (bus.EPC !== 32'h0000_2000) $display("FAIL prio_epc_write_dropped got=%h exp=%h", bus.EPC, 32'h0000_2000);
      else pass_cnt++;
   endtask

   task automatic test_exlclr();
      // EXL is still set and the enabled interrupt line remains high.
      bus.EXLClr = 1'b1;
      bus.PC     = 32'h0000_2500;
      #1;
      total_cnt++;
      if (bus.IntReq !== 1'b0) $display("FAIL eret_no_req got=%b exp=0", bus.IntReq);
      else pass_cnt++;
      step();
      bus.EXLClr = 1'b0;
      bus.A1 = 5'd12; #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0401) $display("FAIL eret_sr got=%h exp=%h", bus.DOut, 32'h0000_0401);
      else pass_cnt++;
      total_cnt++;
      if (bus.IntReq !== 1'b1) $display("FAIL eret_pending_int got=%b exp=1", bus.IntReq);
      else pass_cnt++;
      step();
      bus.HWInt = 6'd0;
      idle();
      #1;
      total_cnt++;
      if (bus.EPC !== 32'h0000_2500) $display("FAIL eret_reentry_epc got=%h exp=%h", bus.EPC, 32'h0000_2500);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      mtc0(5'd12, 32'h0000_0401);
      bus.ExcCode = 5'd10;
      bus.PC      = 32'h0000_0000;
      bus.BD      = 1'b1;
      step();
      idle();
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.EPC !== 32'hFFFF_FFFC) $display("FAIL wrap_epc got=%h exp=%h", bus.EPC, 32'hFFFF_FFFC);
      else pass_cnt++;
      total_cnt++;
      if (bus.DOut !== 32'h8000_0028) $display("FAIL wrap_cause got=%h exp=%h", bus.DOut, 32'h8000_0028);
      else pass_cnt++;
      // The write is not bypassed: mfc0 sees the old value until the edge.
      bus.WE  = 1'b1;
      bus.A2  = 5'd14;
      bus.DIn = 32'h0000_0100;
      bus.A1  = 5'd14;
      #1;
      total_cnt++;
      if (bus.DOut !== 32'hFFFF_FFFC) $display("FAIL no_bypass got=%h exp=%h", bus.DOut, 32'hFFFF_FFFC);
      else pass_cnt++;
      step();
      bus.WE = 1'b0;
      #1;
      total_cnt++;
      if (bus.DOut !== 32'h0000_0100) $display("FAIL write_visible got=%h exp=%h", bus.DOut, 32'h0000_0100);
      else pass_cnt++;
      // Writes to Cause are ignored.
      mtc0(5'd13, 32'hFFFF_FFFF);
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.DOut !== 32'h8000_0028) $display("FAIL cause_readonly got=%h exp=%h", bus.DOut, 32'h8000_0028);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_epc_write_and_reset();
      mtc0(5'd14, 32'h0000_3007);
      bus.A1 = 5'd14; #1;
      total_cnt++;
      if (bus.EPC !== 32'h0000_3004) $display("FAIL epc_write_align got=%h exp=%h", bus.EPC, 32'h0000_3004);
      else pass_cnt++;
      total_cnt++;
      if (bus.DOut !== 32'h0000_3004) $display("FAIL epc_read_align got=%h exp=%h", bus.DOut, 32'h0000_3004);
      else pass_cnt++;
      // EXL is set at this point. Reset must override a concurrent SR write.
      reset   = 1'b1;
      bus.WE  = 1'b1;
      bus.A2  = 5'd12;
      bus.DIn = 32'h0000_0401;
      step();
      reset = 1'b0;
      idle();
      bus.A1 = 5'd12; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL rst_sr got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      bus.A1 = 5'd13; #1;
      total_cnt++;
      if (bus.DOut !== 32'd0) $display("FAIL rst_cause got=%h exp=%h", bus.DOut, 32'd0);
      else pass_cnt++;
      total_cnt++;
      if (bus.EPC !== 32'd0) $display("FAIL rst_epc got=%h exp=%h", bus.EPC, 32'd0);
      else pass_cnt++;
      total_cnt++;
      if (bus.IntReq !== 1'b0) $display("FAIL rst_intreq got=%b exp=0", bus.IntReq);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      bus.HWInt = 6'd0;
      idle();
      test_reset();
      test_int_entry();
      test_exc_entry();
      test_priority();
      test_exlclr();
      test_back_to_back();
      test_epc_write_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception/interrupt arbiter.
- Sits directly downstream of the M-stage exception checker. It consumes the final 5-bit ExcCode for the instruction in M, together with its PC and branch-delay flag.
- Arbitrates hardware interrupts against synchronous exceptions, raises IntReq to flush the pipeline and redirect fetch, and holds SR/Cause/EPC/PrID for mfc0/mtc0/eret.

Parameters:
- PRID, 32'h4C57_0001: read-only PrID contents.
- HANDLER_ADDR, 32'h0000_4180: exception entry address driven on HandlerPC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A1  input  5  mfc0 read register number (rd field).
- A2  input  5  mtc0 write register number (rd field).
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable (M stage).
- PC  input  32  PC of the instruction currently in M.
- BD  input  1  M instruction is in a branch delay slot.
- ExcCode  input  5 [6:2]  final M-stage exception code; 0 = none.
- HWInt  input  6 [7:2]  external interrupt lines (timer0, timer1, uart, switch, key, spare).
- EXLClr  input  1  eret in M: clear SR.EXL.
- IntReq  output  1  take exception/interrupt this cycle (combinational).
- HandlerPC  output  32  constant HANDLER_ADDR.
- EPC  output  32  current EPC register (eret target).
- DOut  output  32  mfc0 read data (combinational on A1).

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits, bits [1:0] always 0.
  - PrID (15): constant PRID.
  - Any other A1 reads 0.
- Reset, synchronous: SR=0, Cause=0, EPC=0. Outputs after reset: IntReq=0, EPC=0, DOut per A1.
- IP sampling: Cause.IP <= HWInt every cycle, including reset release. Not writable by mtc0.
- Request terms:
  - int_req = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - exc_req = (ExcCode != 0) & ~SR.EXL.
  - IntReq = int_req | exc_req. Zero-latency combinational, so the pipeline flushes in the same cycle.
- Priority: interrupt over exception. The recorded code is 0 for an interrupt, else the ExcCode input.
- On IntReq, next edge:
  - SR.EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= recorded code.
  - EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- mtc0 when WE and no IntReq:
  - A2=12 writes IM/EXL/IE from DIn.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Writes to 13 and 15 are ignored.
  - If WE and IntReq coincide, the write is dropped and exception entry wins.
- EXLClr (and no IntReq): SR.EXL <= 0 next edge. IntReq cannot assert in an EXLClr cycle, because EXL is still 1.
- EXL=1 masks all new requests; nested exceptions are not supported. An ExcCode arriving while EXL=1 is ignored, with no state change.
- mtc0 SR clearing EXL takes effect next cycle; a pending enabled interrupt then asserts IntReq on that next cycle.
- mfc0 reads return the pre-edge register value. There is no internal bypass: a same-cycle write is visible on the next cycle.
- PC arithmetic is modulo 2^32. BD with PC=0 gives EPC=32'hFFFF_FFFC.
- Reset mid-exception: reset overrides IntReq/WE/EXLClr, and all registers return to 0.

Test Plan:
- Reset, then A1=15 → DOut=PRID. A1=12/13/14 → 0. IntReq=0 with HWInt=6'h3F, because IE=0.
- mtc0 SR DIn=32'h0000_0401, then HWInt=6'b000001 → IntReq=1 that cycle. Next cycle:
  - SR=32'h0000_0403.
  - Cause ExcCode=0, IP=1.
  - EPC=PC.
  - IntReq=0 while EXL=1.
- EXL=0, ExcCode=5'd5 (AdES), PC=32'h0000_3010, BD=1 → IntReq=1. Next cycle:
  - EPC=32'h0000_300C.
  - Cause=32'h8000_0014 (plus IP bits).
- Simultaneous enabled interrupt and ExcCode=5'd12 → Cause.ExcCode=0, the interrupt wins. WE=1, A2=14 in the same cycle is ignored, and EPC=PC.
- EXL=1, EXLClr=1 → SR.EXL=0 next cycle. With an enabled HWInt still high, IntReq=1 on the following cycle.
- mtc0 EPC DIn=32'h0000_3007 → EPC=32'h0000_3004. Assert reset with EXL=1 → all registers 0 next cycle.
